// File: rtl/button_event.sv
// Button event generator: turns a debounced level into press, release,
// short, long and auto-repeat strobes, plus a held level.
module button_event #(
  parameter int LONG_COUNTS   = 50_000_000,
  parameter int REPEAT_COUNTS = 10_000_000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic button_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam int MAXC = (LONG_COUNTS > REPEAT_COUNTS)
                      ? LONG_COUNTS : REPEAT_COUNTS;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] LONG_C = CW'(LONG_COUNTS);
  localparam logic [CW-1:0] REP_C  = CW'(REPEAT_COUNTS);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] ZERO   = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic press_q, press_d;
  logic rel_q, rel_d;
  logic short_q, short_d;
  logic long_q, long_d;
  logic rep_q, rep_d;
  logic held_q, held_d;

  logic pressed;
  logic long_hit;
  logic rep_hit;

  assign pressed  = button_level ^ ACTIVE_LOW;
  assign long_hit = (cnt_q == LONG_C);
  assign rep_hit  = (cnt_q == REP_C);

  // State, counter and registered strobes; counter holds cycles since entry
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= ZERO;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      short_q <= short_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      held_q  <= held_d;
    end
  end

  // Next state; release beats a terminal count on the same edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = HOLD;
          cnt_d   = ONE;
        end
      end
      HOLD: begin
        if (!pressed) begin
          state_d = IDLE;
          cnt_d   = ZERO;
        end else if (long_hit) begin
          state_d = REPEAT;
          cnt_d   = ONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      REPEAT: begin
        if (!pressed) begin
          state_d = IDLE;
          cnt_d   = ZERO;
        end else if (rep_hit) begin
          cnt_d = ONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = ZERO;
      end
    endcase
  end

  // Strobe decode from the current state and the sampled level
  always_comb begin
    press_d = 1'b0;
    rel_d   = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    held_d  = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        press_d = pressed;
      end
      HOLD: begin
        rel_d   = !pressed;
        short_d = !pressed;
        long_d  = pressed && long_hit;
      end
      REPEAT: begin
        rel_d = !pressed;
        rep_d = pressed && rep_hit;
      end
      default: begin
        press_d = 1'b0;
      end
    endcase
  end

  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign short_press   = short_q;
  assign long_press    = long_q;
  assign repeat_pulse  = rep_q;
  assign held          = held_q;

endmodule
